// File: rtl/rf_pkg.sv
// Shared types and widths for the register-file write buffer.
// A queue entry is the {destination register, value} pair of one writeback.
package rf_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned NUM_REGS = 16;

    localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

    typedef struct packed {
        logic [REG_W-1:0]  rid;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_write_buffer_if.sv
// Pipeline-side, register-file-side and lookup signals of the write buffer.
// The buffer is the slave; whoever feeds writebacks and consumes rf_* is the master.
interface rf_write_buffer_if
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [REG_W-1:0]  in_reg;
    logic [DATA_W-1:0] in_data;

    logic              rf_grant;
    logic              rf_wen;
    logic [REG_W-1:0]  rf_dst;
    logic [DATA_W-1:0] rf_data;

    logic [REG_W-1:0]  lk_reg1;
    logic [REG_W-1:0]  lk_reg2;
    logic              lk_hit1;
    logic              lk_hit2;
    logic [DATA_W-1:0] lk_data1;
    logic [DATA_W-1:0] lk_data2;

    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_reg, in_data, rf_grant, lk_reg1, lk_reg2,
        input  in_ready, rf_wen, rf_dst, rf_data,
        input  lk_hit1, lk_hit2, lk_data1, lk_data2, count
    );

    modport slave (
        input  in_valid, in_reg, in_data, rf_grant, lk_reg1, lk_reg2,
        output in_ready, rf_wen, rf_dst, rf_data,
        output lk_hit1, lk_hit2, lk_data1, lk_data2, count
    );

endinterface

// File: rtl/rf_fwd_match.sv
// Forwarding lookup for one read port: finds the youngest valid queued
// write to lk_reg. Register 0 never matches.
module rf_fwd_match
    import rf_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]      valid,
    input  logic [PTR_W-1:0]      tail,
    input  logic [REG_W-1:0]      lk_reg,
    output logic                  hit,
    output logic [DATA_W-1:0]     data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest (tail-DEPTH) to youngest (tail-1); later matches shadow earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = int'(DEPTH); k >= 1; k--) begin
            idx = tail - PTR_W'(k);
            if (valid[idx] && (entries[idx].rid == lk_reg) && (lk_reg != REG_ZERO)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/rf_write_buffer.sv
// Write-side initiator for the register file: queues writebacks in a small
// circular FIFO, drains them in order when granted, and forwards pending values.
module rf_write_buffer
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    rf_write_buffer_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0]      vld_q;
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      cnt_q;

    logic ready;
    logic nonempty;
    logic store;
    logic pop;

    // Room is judged on the current count only; a same-cycle pop does not help.
    always_comb begin
        ready    = cnt_q < CNT_W'(DEPTH);
        nonempty = cnt_q != CNT_W'(0);
        store    = bus.in_valid && ready && (bus.in_reg != REG_ZERO);
        pop      = nonempty && bus.rf_grant;
    end

    assign bus.in_ready = ready;
    assign bus.rf_wen   = pop;
    assign bus.rf_dst   = nonempty ? mem_q[head_q].rid  : '0;
    assign bus.rf_data  = nonempty ? mem_q[head_q].data : '0;
    assign bus.count    = cnt_q;

    // R0 writes complete the handshake but are dropped here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '0;
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (store) begin
                mem_q[tail_q] <= '{rid: bus.in_reg, data: bus.in_data};
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(store) - CNT_W'(pop);
        end
    end

    rf_fwd_match #(.DEPTH(DEPTH)) u_match1 (
        .entries (mem_q),
        .valid   (vld_q),
        .tail    (tail_q),
        .lk_reg  (bus.lk_reg1),
        .hit     (bus.lk_hit1),
        .data    (bus.lk_data1)
    );

    rf_fwd_match #(.DEPTH(DEPTH)) u_match2 (
        .entries (mem_q),
        .valid   (vld_q),
        .tail    (tail_q),
        .lk_reg  (bus.lk_reg2),
        .hit     (bus.lk_hit2),
        .data    (bus.lk_data2)
    );

endmodule

// File: tb/tb_rf_write_buffer.sv
// Bench for rf_write_buffer: queue-based reference model compared every
// negedge, directed scenarios with literal expectations, then random traffic.
module tb_rf_write_buffer;
    import rf_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_write_buffer_if #(.DEPTH(DEPTH)) bus ();

    rf_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: pending writes in acceptance order, oldest at index 0.
    wb_entry_t mq[$];

    function automatic logic [DATA_W:0] model_lookup(input logic [REG_W-1:0] r);
        if (r == REG_ZERO) return '0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].rid == r) return {1'b1, mq[i].data};
        return '0;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit rd;
        bit wn;
        if (rst) begin
            mq.delete();
        end else begin
            rd = mq.size() < DEPTH;
            wn = (mq.size() != 0) && bus.rf_grant;
            if (wn) void'(mq.pop_front());
            if (bus.in_valid && rd && (bus.in_reg != REG_ZERO))
                mq.push_back('{rid: bus.in_reg, data: bus.in_data});
        end
    end

    always @(negedge clk) begin
        logic [DATA_W:0] l1;
        logic [DATA_W:0] l2;
        l1 = model_lookup(bus.lk_reg1);
        l2 = model_lookup(bus.lk_reg2);
        chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        chk("count",    32'(bus.count),    32'(mq.size()));
        chk("rf_wen",   32'(bus.rf_wen),   32'((mq.size() != 0) && bus.rf_grant));
        chk("rf_dst",   32'(bus.rf_dst),   (mq.size() != 0) ? 32'(mq[0].rid)  : 32'd0);
        chk("rf_data",  32'(bus.rf_data),  (mq.size() != 0) ? 32'(mq[0].data) : 32'd0);
        chk("lk_hit1",  32'(bus.lk_hit1),  32'(l1[DATA_W]));
        chk("lk_data1", 32'(bus.lk_data1), 32'(l1[DATA_W-1:0]));
        chk("lk_hit2",  32'(bus.lk_hit2),  32'(l2[DATA_W]));
        chk("lk_data2", 32'(bus.lk_data2), 32'(l2[DATA_W-1:0]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int unsigned r, input int unsigned d);
        bus.in_valid = 1'b1;
        bus.in_reg   = REG_W'(r);
        bus.in_data  = DATA_W'(d);
        tick();
    endtask

    initial begin
        int unsigned order [4];
        bit took;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_reg   = '0;
        bus.in_data  = '0;
        bus.rf_grant = 1'b0;
        bus.lk_reg1  = 4'd3;
        bus.lk_reg2  = 4'd5;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);

        // Idle with grant
        bus.rf_grant = 1'b1;
        tick();
        #1;
        chk("idle_wen", 32'(bus.rf_wen), 32'd0);
        chk("idle_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_count", 32'(bus.count), 32'd0);
        chk("idle_hit1", 32'(bus.lk_hit1), 32'd0);
        chk("idle_hit2", 32'(bus.lk_hit2), 32'd0);

        // Single write, held off then drained
        bus.rf_grant = 1'b0;
        push(3, 16'h1234);
        bus.in_valid = 1'b0;
        #1;
        chk("r3_count", 32'(bus.count), 32'd1);
        chk("r3_hit1", 32'(bus.lk_hit1), 32'd1);
        chk("r3_data1", 32'(bus.lk_data1), 32'h1234);
        chk("r3_wen_nogrant", 32'(bus.rf_wen), 32'd0);
        bus.rf_grant = 1'b1;
        #1;
        chk("r3_wen", 32'(bus.rf_wen), 32'd1);
        chk("r3_dst", 32'(bus.rf_dst), 32'd3);
        chk("r3_rfdata", 32'(bus.rf_data), 32'h1234);
        tick();
        #1;
        chk("r3_count_after", 32'(bus.count), 32'd0);
        chk("r3_wen_after", 32'(bus.rf_wen), 32'd0);
        chk("r3_hit_after", 32'(bus.lk_hit1), 32'd0);

        // Duplicate register: youngest forwarded, both drain oldest first
        bus.rf_grant = 1'b0;
        push(5, 16'h00AA);
        push(5, 16'h00BB);
        bus.in_valid = 1'b0;
        #1;
        chk("dup_count", 32'(bus.count), 32'd2);
        chk("dup_data2", 32'(bus.lk_data2), 32'h00BB);
        bus.rf_grant = 1'b1;
        #1;
        chk("dup_drain1", 32'(bus.rf_data), 32'h00AA);
        chk("dup_fwd1", 32'(bus.lk_data2), 32'h00BB);
        tick();
        #1;
        chk("dup_drain2", 32'(bus.rf_data), 32'h00BB);
        chk("dup_fwd2", 32'(bus.lk_data2), 32'h00BB);
        tick();
        #1;
        chk("dup_empty", 32'(bus.count), 32'd0);
        chk("dup_hit_empty", 32'(bus.lk_hit2), 32'd0);

        // Full: no same-cycle room from a pop
        bus.rf_grant = 1'b0;
        for (int i = 1; i <= 4; i++) push(i, 16'h0100 + i);
        bus.in_valid = 1'b1;
        bus.in_reg   = 4'd6;
        bus.in_data  = 16'h0106;
        #1;
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        chk("full_count", 32'(bus.count), 32'd4);
        bus.rf_grant = 1'b1;
        #1;
        chk("full_ready_pop", 32'(bus.in_ready), 32'd0);
        chk("full_dst1", 32'(bus.rf_dst), 32'd1);
        tick();
        bus.rf_grant = 1'b0;
        #1;
        chk("full_count3", 32'(bus.count), 32'd3);
        chk("full_ready3", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("full_count4", 32'(bus.count), 32'd4);
        bus.rf_grant = 1'b1;
        order = '{2, 3, 4, 6};
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("full_order_dst", 32'(bus.rf_dst), 32'(order[i]));
            chk("full_order_data", 32'(bus.rf_data), 32'h0100 + 32'(order[i]));
            tick();
        end
        #1;
        chk("full_drained", 32'(bus.count), 32'd0);

        // R0 filter
        bus.lk_reg1  = 4'd0;
        bus.in_valid = 1'b1;
        bus.in_reg   = 4'd0;
        bus.in_data  = 16'hFFFF;
        #1;
        chk("r0_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("r0_count", 32'(bus.count), 32'd0);
        chk("r0_wen", 32'(bus.rf_wen), 32'd0);
        chk("r0_hit", 32'(bus.lk_hit1), 32'd0);
        tick();
        chk("r0_wen2", 32'(bus.rf_wen), 32'd0);

        // Asynchronous reset mid-cycle with pending entries
        bus.rf_grant = 1'b0;
        push(7, 16'h0777);
        push(8, 16'h0888);
        push(9, 16'h0999);
        bus.in_valid = 1'b0;
        bus.lk_reg1  = 4'd7;
        bus.lk_reg2  = 4'd9;
        #1;
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        chk("pre_rst_hit1", 32'(bus.lk_hit1), 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        bus.rf_grant = 1'b1;
        #1;
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_wen", 32'(bus.rf_wen), 32'd0);
        chk("arst_hit1", 32'(bus.lk_hit1), 32'd0);
        chk("arst_hit2", 32'(bus.lk_hit2), 32'd0);
        chk("arst_ready", 32'(bus.in_ready), 32'd1);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_wen", 32'(bus.rf_wen), 32'd0);
            chk("post_rst_count", 32'(bus.count), 32'd0);
        end

        // Random traffic; an unaccepted request is held stable
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            #1 took = bus.in_valid && (mq.size() < DEPTH);
            @(posedge clk);
            #1;
            if (!bus.in_valid || took) begin
                bus.in_valid = $urandom_range(0, 3) != 0;
                bus.in_reg   = REG_W'($urandom_range(0, 7));
                bus.in_data  = DATA_W'($urandom);
            end
            bus.rf_grant = $urandom_range(0, 9) < 5;
            bus.lk_reg1  = REG_W'($urandom_range(0, 7));
            bus.lk_reg2  = REG_W'($urandom_range(0, 7));
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
